my_design: RTL and testbench
============================

Name: my_design

Overview:
- Multiprecision fully-connected layer engine.
- For each packed input vector in the input SRAM, it computes signed dot products against every packed weight row in the weight SRAM.
- Each result is saturated to a 16-bit signed value and written to the output SRAM.
- Sits between three single-port-style SRAMs (input, weight, output), each 12-bit address, 16-bit data, and a run/busy controller.

Parameters:
- ADDR_WIDTH, 12, SRAM address width.
- DATA_WIDTH, 16, SRAM word width.
- VEC_LEN, 16, elements per input vector and per weight row.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_b  in  1  synchronous, active-low reset.
- dut_run  in  1  start request, level-sampled in IDLE.
- dut_busy  out  1  high while a job is in progress.
- dut_sram_read_address  out  12  input SRAM read address.
- sram_dut_read_data  in  16  input SRAM read data, valid 1 cycle after address.
- dut_wmem_read_address  out  12  weight SRAM read address.
- wmem_dut_read_data  in  16  weight SRAM read data, valid 1 cycle after address.
- dut_sram_write_address  out  12  output SRAM write address.
- dut_sram_write_data  out  16  output SRAM write data.
- dut_sram_write_enable  out  1  output SRAM write strobe, one word per cycle.

Behaviour:
- Reset (reset_b=0 at a clk edge): all outputs 0, FSM to IDLE, accumulators cleared. Also applies mid-job; the job is abandoned and no further writes occur.
- Memory map:
  - input[0] = V, number of vectors (unsigned 16-bit).
  - weight[0] = config: bits[1:0] mode, bits[11:4] R (row count); other bits ignored.
- Mode:
  - 00: 8-bit signed, 2 elements/word.
  - 01: 4-bit signed, 4 elements/word.
  - 10: 2-bit signed, 8 elements/word.
  - 11: treated as 00.
- Words per vector/row: W = 16/epw, giving 8/4/2.
- Packing: element 0 in bits [b-1:0], ascending upward.
- Vector v is at input[1+v*W .. v*W+W]; row r is at weight[1+r*W .. r*W+W].
- Result(v,r) = sum over e=0..15 of x[v][e]*w[r][e]:
  - 20-bit signed accumulator.
  - Saturated to [-32768, 32767].
  - Written at output address v*R+r.
- Results leave in order v-major, r-minor.
- SRAM reads are synchronous with 1-cycle latency; consecutive addresses may be issued back-to-back (pipelined).
- FSM states:
  - IDLE: busy=0; on dut_run=1 go to CFG. busy rises on the next clock edge.
  - CFG: read both header words, latch V, R, mode.
  - LOADV: read W words of vector v into a 128-bit vector register.
  - MAC: for each row, read W weight words. Each returned word is combined with the matching vector word; all epw products are added in the same cycle.
  - WRITE: one cycle with write_enable=1.
  - Then next row. After the last row, next vector (back to LOADV). After the last vector, DONE.
  - DONE: one cycle, busy=0, back to IDLE.
- Boundary cases:
  - V=0 or R=0: no writes; busy drops within 4 cycles of CFG.
  - dut_run is ignored while busy. A new job starts only from IDLE. dut_run still high on return to IDLE restarts the job, so the controller must drop run within 2 cycles of busy rising.
  - write_enable is never high outside WRITE; write address and data are held stable during that cycle.
- Throughput target: at most W+3 cycles per result.

Optional Feature:
- RELU_EN:
  - When defined, negative saturated results are written as 0x0000.
  - When undefined, signed saturated results are written unchanged.

Decomposition:
- Package my_design_pkg holds:
  - mode enum (MODE_8B, MODE_4B, MODE_2B);
  - FSM state enum;
  - ACC_WIDTH=20, VEC_LEN, SAT_MAX/SAT_MIN constants;
  - function words_per_vec(mode).
- One sub-module, mp_word_mac: combinational. Inputs: 16-bit x word, 16-bit w word, mode. Output: sign-extended sum of the per-element products (up to 8 lanes).

Test Plan:
- Mode 00, V=6, R=16, all x=1, all w=-1 (0xFFFF words) → 96 writes at addresses 0..95, each 0xFFF0 (-16); busy falls after the last write.
- Mode 01, V=9, R=16, x=7, w=7 → 144 writes of 0x0310 (784); address 143 is the last written.
- Mode 00 saturation: x=127, w=127 for all elements → 0x7FFF; x=-128, w=127 → 0x8000 (0x0000 with RELU_EN).
- Mode 10, V=1, R=2, row0=+1s, row1=-2s, x=1s → output[0]=0x0010, output[1]=0xFFE0.
- V=0 → no write_enable pulse; busy high for at most 5 cycles. Two back-to-back jobs with new SRAM contents both produce correct results.
- Pulling reset_b low mid-job for one cycle → busy=0 and write_enable=0 on the next edge; a fresh dut_run completes the job correctly.

Source files
------------

// File: rtl/my_design_pkg.sv
// Shared types and constants for the multiprecision fully-connected layer engine.
// Lane modes, controller states, accumulator sizing and saturation limits.
package my_design_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 16;
  localparam int VEC_LEN    = 16;
  localparam int ACC_WIDTH  = 20;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = 20'sd32767;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -20'sd32768;

  typedef enum logic [1:0] {
    MODE_8B = 2'b00,
    MODE_4B = 2'b01,
    MODE_2B = 2'b10
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOADV,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic logic [3:0] words_per_vec(input mode_t m);
    case (m)
      MODE_4B: return 4'd4;
      MODE_2B: return 4'd2;
      default: return 4'd8;
    endcase
  endfunction

  // The unused encoding 2'b11 falls back to 8-bit lanes.
  function automatic mode_t decode_mode(input logic [1:0] bits);
    case (bits)
      2'b01:   return MODE_4B;
      2'b10:   return MODE_2B;
      default: return MODE_8B;
    endcase
  endfunction

endpackage

// File: rtl/my_design_if.sv
// Run/busy control plus the three SRAM ports of the layer engine.
// master = engine side, slave = controller/memory side.
interface my_design_if;
  import my_design_pkg::*;

  logic                  dut_run;
  logic                  dut_busy;
  logic [ADDR_WIDTH-1:0] dut_sram_read_address;
  logic [DATA_WIDTH-1:0] sram_dut_read_data;
  logic [ADDR_WIDTH-1:0] dut_wmem_read_address;
  logic [DATA_WIDTH-1:0] wmem_dut_read_data;
  logic [ADDR_WIDTH-1:0] dut_sram_write_address;
  logic [DATA_WIDTH-1:0] dut_sram_write_data;
  logic                  dut_sram_write_enable;

  modport master (
    input  dut_run, sram_dut_read_data, wmem_dut_read_data,
    output dut_busy, dut_sram_read_address, dut_wmem_read_address,
           dut_sram_write_address, dut_sram_write_data, dut_sram_write_enable
  );

  modport slave (
    output dut_run, sram_dut_read_data, wmem_dut_read_data,
    input  dut_busy, dut_sram_read_address, dut_wmem_read_address,
           dut_sram_write_address, dut_sram_write_data, dut_sram_write_enable
  );

endinterface

// File: rtl/my_design_mp_word_mac.sv
// Combinational packed-word dot product: 2x8b, 4x4b or 8x2b signed lanes summed.
// Zero latency, no flow control.
module mp_word_mac
  import my_design_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]        x_word,
  input  logic [DATA_WIDTH-1:0]        w_word,
  input  mode_t                        mode,
  output logic signed [ACC_WIDTH-1:0]  sum
);

  always_comb begin
    sum = '0;
    case (mode)
      MODE_4B: begin
        for (int i = 0; i < 4; i++)
          sum = sum + ACC_WIDTH'($signed(x_word[4*i +: 4])) * ACC_WIDTH'($signed(w_word[4*i +: 4]));
      end
      MODE_2B: begin
        for (int i = 0; i < 8; i++)
          sum = sum + ACC_WIDTH'($signed(x_word[2*i +: 2])) * ACC_WIDTH'($signed(w_word[2*i +: 2]));
      end
      default: begin
        for (int i = 0; i < 2; i++)
          sum = sum + ACC_WIDTH'($signed(x_word[8*i +: 8])) * ACC_WIDTH'($signed(w_word[8*i +: 8]));
      end
    endcase
  end

endmodule

// File: rtl/my_design.sv
// Fully-connected layer engine: every input vector dotted with every weight row, saturated to 16 bits.
// W+2 cycles per result, no backpressure; RELU_EN clamps negative results to zero.
module my_design
  import my_design_pkg::*;
(
  input  logic       clk,
  input  logic       reset_b,
  my_design_if.master bus
);

  state_t state, nxt;
  mode_t  mode_q;

  logic [15:0]                   v_num, vec_q;
  logic [7:0]                    r_num, row_q;
  logic [ADDR_WIDTH-1:0]         rd_addr, wt_addr, wr_addr, wr_cnt;
  logic [DATA_WIDTH-1:0]         wr_data, result, x_word;
  logic [VEC_LEN*8-1:0]          vreg;
  logic signed [ACC_WIDTH-1:0]   acc, acc_nxt, mac_sum;
  logic                          a_vld, d_vld;
  logic [2:0]                    a_idx, d_idx;
  logic [3:0]                    wpv;
  logic                          d_last, last_row, last_vec, cfg_empty;
  logic                          start_burst, more_issue;
  logic                          unused_cfg_bits;

  assign wpv       = words_per_vec(mode_q);
  assign d_last    = d_vld && ({1'b0, d_idx} == wpv - 4'd1);
  assign last_row  = (row_q == r_num - 8'd1);
  assign last_vec  = (vec_q == v_num - 16'd1);
  assign cfg_empty = (bus.sram_dut_read_data == '0) || (bus.wmem_dut_read_data[11:4] == '0);
  assign x_word    = vreg[d_idx*DATA_WIDTH +: DATA_WIDTH];
  assign unused_cfg_bits = ^{bus.wmem_dut_read_data[15:12], bus.wmem_dut_read_data[3:2]};

  mp_word_mac u_mac (
    .x_word (x_word),
    .w_word (bus.wmem_dut_read_data),
    .mode   (mode_q),
    .sum    (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (!reset_b) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (bus.dut_run) nxt = S_CFG;
      S_CFG:   if (d_vld) nxt = cfg_empty ? S_DONE : S_LOADV;
      S_LOADV: if (d_last) nxt = S_MAC;
      S_MAC:   if (d_last) nxt = S_WRITE;
      S_WRITE: nxt = !last_row ? S_MAC : (last_vec ? S_DONE : S_LOADV);
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // A burst is W back-to-back reads; the first address is loaded on the entry edge.
  assign start_burst = (nxt != state) && (nxt == S_LOADV || nxt == S_MAC);
  assign more_issue  = a_vld && ({1'b0, a_idx} != wpv - 4'd1) &&
                       (state == S_LOADV || state == S_MAC);

  always_comb begin
    acc_nxt = acc + mac_sum;
    if (acc_nxt > SAT_MAX)      result = 16'h7FFF;
    else if (acc_nxt < SAT_MIN) result = 16'h8000;
    else                        result = acc_nxt[15:0];
`ifdef RELU_EN
    if (acc_nxt[ACC_WIDTH-1]) result = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      mode_q  <= MODE_8B;
      v_num   <= '0;
      r_num   <= '0;
      vec_q   <= '0;
      row_q   <= '0;
      rd_addr <= '0;
      wt_addr <= '0;
      wr_addr <= '0;
      wr_cnt  <= '0;
      wr_data <= '0;
      vreg    <= '0;
      acc     <= '0;
      a_vld   <= 1'b0;
      d_vld   <= 1'b0;
      a_idx   <= '0;
      d_idx   <= '0;
    end else begin
      d_vld <= a_vld;
      d_idx <= a_idx;
      a_vld <= 1'b0;
      if (state == S_IDLE && nxt == S_CFG) begin
        a_vld   <= 1'b1;
        a_idx   <= '0;
        rd_addr <= '0;
        wt_addr <= '0;
        wr_cnt  <= '0;
      end else if (start_burst) begin
        a_vld <= 1'b1;
        a_idx <= '0;
        if (nxt == S_LOADV) rd_addr <= rd_addr + 12'd1;
        else                wt_addr <= (state == S_LOADV) ? 12'd1 : wt_addr + 12'd1;
      end else if (more_issue) begin
        a_vld <= 1'b1;
        a_idx <= a_idx + 3'd1;
        if (state == S_LOADV) rd_addr <= rd_addr + 12'd1;
        else                  wt_addr <= wt_addr + 12'd1;
      end

      if (state == S_CFG && d_vld) begin
        v_num  <= bus.sram_dut_read_data;
        r_num  <= bus.wmem_dut_read_data[11:4];
        mode_q <= decode_mode(bus.wmem_dut_read_data[1:0]);
        vec_q  <= '0;
        row_q  <= '0;
        acc    <= '0;
      end

      if (state == S_LOADV && d_vld)
        vreg[d_idx*DATA_WIDTH +: DATA_WIDTH] <= bus.sram_dut_read_data;

      if (state == S_MAC && d_vld) begin
        if (d_last) begin
          acc     <= '0;
          wr_data <= result;
          wr_addr <= wr_cnt;
          wr_cnt  <= wr_cnt + 12'd1;
        end else begin
          acc <= acc_nxt;
        end
      end

      if (state == S_WRITE) begin
        if (last_row) begin
          row_q <= '0;
          vec_q <= vec_q + 16'd1;
        end else begin
          row_q <= row_q + 8'd1;
        end
      end
    end
  end

  assign bus.dut_busy               = (state == S_CFG) || (state == S_LOADV) ||
                                      (state == S_MAC) || (state == S_WRITE);
  assign bus.dut_sram_read_address  = rd_addr;
  assign bus.dut_wmem_read_address  = wt_addr;
  assign bus.dut_sram_write_address = wr_addr;
  assign bus.dut_sram_write_data    = wr_data;
  assign bus.dut_sram_write_enable  = (state == S_WRITE);

endmodule

// File: tb/tb_my_design.sv
// Scoreboard bench for my_design: element-level reference model feeds an expected-write queue,
// a negedge monitor pops and compares every output SRAM write.
module tb_my_design;

  logic clk, reset_b;
  my_design_if bif();

  my_design dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] imem [0:4095];
  logic [15:0] wmem [0:4095];

  always @(posedge clk) begin
    bif.sram_dut_read_data <= imem[bif.dut_sram_read_address];
    bif.wmem_dut_read_data <= wmem[bif.dut_wmem_read_address];
  end

  typedef struct { int addr; int data; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;
  int xel [0:15][0:15];
  int wel [0:15][0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_b === 1'b1 && bif.dut_sram_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required=no write",
                 bif.dut_sram_write_address, bif.dut_sram_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bif.dut_sram_write_address), 32'(mon_e.addr));
        check("wr_data", 32'(bif.dut_sram_write_data), 32'(mon_e.data));
      end
    end
  end

  function automatic int epw_of(input int mbits);
    int eff;
    eff = (mbits == 3) ? 0 : mbits;
    return (eff == 0) ? 2 : (eff == 1) ? 4 : 8;
  endfunction

  task automatic fill_const(input int nv, input int nr, input int xv, input int wv);
    for (int v = 0; v < nv; v++) for (int e = 0; e < 16; e++) xel[v][e] = xv;
    for (int r = 0; r < nr; r++) for (int e = 0; e < 16; e++) wel[r][e] = wv;
  endtask

  task automatic fill_rand(input int mbits, input int nv, input int nr);
    int b;
    b = 16 / epw_of(mbits);
    for (int v = 0; v < nv; v++) for (int e = 0; e < 16; e++)
      xel[v][e] = int'($urandom_range(0, (1 << b) - 1)) - (1 << (b - 1));
    for (int r = 0; r < nr; r++) for (int e = 0; e < 16; e++)
      wel[r][e] = int'($urandom_range(0, (1 << b) - 1)) - (1 << (b - 1));
  endtask

  // Pack element arrays into SRAM words, lane 0 in the low bits.
  task automatic load(input int mbits, input int nv, input int nr, input int junk);
    int epw, b, word;
    epw = epw_of(mbits);
    b   = 16 / epw;
    imem[0] = 16'(nv);
    wmem[0] = 16'((junk & 'hF00C) | (nr << 4) | mbits);
    for (int v = 0; v < nv; v++)
      for (int j = 0; j < 16 / epw; j++) begin
        word = 0;
        for (int l = 0; l < epw; l++)
          word = word | ((xel[v][j*epw+l] & ((1 << b) - 1)) << (l * b));
        imem[1 + v*(16/epw) + j] = 16'(word);
      end
    for (int r = 0; r < nr; r++)
      for (int j = 0; j < 16 / epw; j++) begin
        word = 0;
        for (int l = 0; l < epw; l++)
          word = word | ((wel[r][j*epw+l] & ((1 << b) - 1)) << (l * b));
        wmem[1 + r*(16/epw) + j] = 16'(word);
      end
  endtask

  task automatic push_expected(input int nv, input int nr);
    int acc;
    for (int v = 0; v < nv; v++)
      for (int r = 0; r < nr; r++) begin
        acc = 0;
        for (int e = 0; e < 16; e++) acc += xel[v][e] * wel[r][e];
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
`ifdef RELU_EN
        if (acc < 0) acc = 0;
`endif
        exp_q.push_back('{(v * nr + r) % 4096, acc & 'hFFFF});
      end
  endtask

  // Busy-cycle allowance: empty jobs at most 5 cycles, otherwise W+3 per vector load and per result.
  function automatic int busy_limit(input int mbits, input int nv, input int nr);
    int w;
    w = 16 / epw_of(mbits);
    if (nv == 0 || nr == 0) return 5;
    return 6 + nv * (w + 3) + nv * nr * (w + 3);
  endfunction

  task automatic run_job(input int limit);
    int cnt;
    @(negedge clk);
    bif.dut_run = 1'b1;
    @(negedge clk);
    bif.dut_run = 1'b0;
    check("busy_rise", 32'(bif.dut_busy), 32'd1);
    cnt = 1;
    while (bif.dut_busy === 1'b1 && cnt < 4000) begin
      @(negedge clk);
      cnt++;
    end
    check("job_end_busy", 32'(bif.dut_busy), 32'd0);
    check("busy_cycles_ok", 32'(cnt - 1 <= limit), 32'd1);
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_after", 32'(bif.dut_busy), 32'd0);
  endtask

  task automatic job(input int mbits, input int nv, input int nr, input int junk);
    load(mbits, nv, nr, junk);
    push_expected(nv, nr);
    run_job(busy_limit(mbits, nv, nr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mb, nv, nr;
    bif.dut_run = 1'b0;
    reset_b = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      imem[i] = '0;
      wmem[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bif.dut_busy), 32'd0);
    check("rst_we", 32'(bif.dut_sram_write_enable), 32'd0);
    check("rst_waddr", 32'(bif.dut_sram_write_address), 32'd0);
    check("rst_wdata", 32'(bif.dut_sram_write_data), 32'd0);
    check("rst_raddr", 32'(bif.dut_sram_read_address), 32'd0);
    check("rst_wmaddr", 32'(bif.dut_wmem_read_address), 32'd0);
    reset_b = 1'b1;
    @(negedge clk);

    fill_const(6, 16, 1, -1);
    job(0, 6, 16, 0);
    fill_const(9, 16, 7, 7);
    job(1, 9, 16, 0);

    fill_const(2, 1, 127, 127);
    for (int e = 0; e < 16; e++) xel[1][e] = -128;
    job(0, 2, 1, 'hF00C);

    fill_const(1, 2, 1, 1);
    for (int e = 0; e < 16; e++) wel[1][e] = -2;
    job(2, 1, 2, 0);

    job(0, 0, 5, 0);
    job(1, 3, 0, 'h5004);

    for (int i = 0; i < 6; i++) begin
      mb = (i == 0) ? 3 : int'($urandom_range(0, 3));
      nv = int'($urandom_range(1, 4));
      nr = int'($urandom_range(1, 6));
      fill_rand(mb, nv, nr);
      job(mb, nv, nr, int'($urandom_range(0, 'hFFFF)));
    end

    fill_rand(1, 3, 4);
    load(1, 3, 4, 0);
    push_expected(3, 4);
    @(negedge clk);
    bif.dut_run = 1'b1;
    @(negedge clk);
    bif.dut_run = 1'b0;
    repeat (17) @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(bif.dut_busy), 32'd0);
    check("midrst_we", 32'(bif.dut_sram_write_enable), 32'd0);
    reset_b = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_expected(3, 4);
    run_job(busy_limit(1, 3, 4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
